// File: rtl/shared_ram_arb_pkg.sv
// Shared definitions for the shared work-RAM arbiter.
//   arb_state_e : sequencer states (IDLE -> ACCESS -> DATA -> IDLE)
//   DEF_NREQ    : default number of requesters (main, sub, sound CPU)
//   DEF_AW      : default shared-RAM address width (2 KB)
//   slice_lo()  : low bit index of slot idx in a packed vector of width-bit slots
package shared_ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DATA   = 2'd2
  } arb_state_e;

  localparam int DEF_NREQ = 3;
  localparam int DEF_AW   = 11;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Shared with the interrupt/NMI scheduling
// logic, so it carries no state of its own.
//   pend_i : per-requester pending vector
//   last_i : index of the most recent winner
//   win_o  : winner, first pending requester searching from last_i+1 mod NREQ
//   any_o  : at least one requester is pending
module rr_pick
  import shared_ram_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] pend_i,
  input  logic [IW-1:0]   last_i,
  output logic [IW-1:0]   win_o,
  output logic            any_o
);

  logic [IW-1:0] idx;

  // Walk from the farthest candidate to the nearest so that the nearest
  // pending requester after last_i is the one left in win_o.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last_i) + k) % NREQ);
      if (pend_i[idx]) begin
        win_o = idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_ram_arbiter.sv
// Shares one single-port synchronous work RAM between NREQ CPU cores.
// One access at a time, three cycles each (IDLE grant, ACCESS, DATA).
//
// Handshake: a requester raises REQ_RD or REQ_WR (level) and holds it until
// it sees REQ_DV. REQ_DV stays high while the strobe is held; the requester
// must then drop both strobes for at least one cycle before its next access.
// RD and WR together count as a write.
//
// Ports:
//   CLK, RESET_N        : clock, synchronous active-low reset
//   REQ_RD/REQ_WR       : per-requester read/write strobes
//   REQ_AD/REQ_DO       : packed per-requester address / write data
//   REQ_DI/REQ_DV       : packed per-requester read data / access complete
//   RAM_AD/RAM_WE/RAM_DO: registered RAM address, write enable, write data
//   RAM_DI              : RAM read data, one cycle after RAM_AD
//   DBG_STATE           : current sequencer state (arb_state_e encoding)
module shared_ram_arbiter
  import shared_ram_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NREQ-1:0]   REQ_RD,
  input  logic [NREQ-1:0]   REQ_WR,
  input  logic [NREQ*AW-1:0] REQ_AD,
  input  logic [NREQ*8-1:0] REQ_DO,
  output logic [NREQ*8-1:0] REQ_DI,
  output logic [NREQ-1:0]   REQ_DV,
  output logic [AW-1:0]     RAM_AD,
  output logic              RAM_WE,
  output logic [7:0]        RAM_DO,
  input  logic [7:0]        RAM_DI,
  output logic [1:0]        DBG_STATE
);

  localparam int IW = $clog2(NREQ);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     win_q, win_d;
  logic              wr_q, wr_d;
  logic [NREQ-1:0]   served_q, served_d;
  logic [AW-1:0]     ram_ad_q, ram_ad_d;
  logic [7:0]        ram_do_q, ram_do_d;
  logic              ram_we_q, ram_we_d;
  logic [NREQ*8-1:0] di_q, di_d;

  logic [NREQ-1:0]   active;
  logic [NREQ-1:0]   pend;
  logic [IW-1:0]     pick_win;
  logic              pick_any;

  assign active = REQ_RD | REQ_WR;
  assign pend   = active & ~served_q;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .pend_i (pend),
    .last_i (last_q),
    .win_o  (pick_win),
    .any_o  (pick_any)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_any) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DATA;
      ST_DATA:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    last_d   = last_q;
    win_d    = win_q;
    wr_d     = wr_q;
    ram_ad_d = ram_ad_q;
    ram_do_d = ram_do_q;
    ram_we_d = 1'b0;      // write strobe lasts only the ACCESS cycle
    di_d     = di_q;

    // served drops once the requester releases both strobes.
    for (int i = 0; i < NREQ; i++) begin
      served_d[i] = active[i] ? served_q[i] : 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d    = pick_win;
          wr_d     = REQ_WR[pick_win];
          ram_we_d = REQ_WR[pick_win];
          ram_ad_d = REQ_AD[slice_lo(int'(pick_win), AW) +: AW];
          ram_do_d = REQ_DO[slice_lo(int'(pick_win), 8) +: 8];
        end
      end
      ST_DATA: begin
        // Completes even if the requester withdrew after the grant; served
        // then falls on the following cycle so REQ_DV never shows.
        if (!wr_q) di_d[slice_lo(int'(win_q), 8) +: 8] = RAM_DI;
        served_d[win_q] = 1'b1;
        last_d          = win_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      last_q   <= IW'(NREQ - 1);
      win_q    <= '0;
      wr_q     <= 1'b0;
      served_q <= '0;
      ram_ad_q <= '0;
      ram_do_q <= '0;
      ram_we_q <= 1'b0;
      di_q     <= '0;
    end else begin
      last_q   <= last_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      served_q <= served_d;
      ram_ad_q <= ram_ad_d;
      ram_do_q <= ram_do_d;
      ram_we_q <= ram_we_d;
      di_q     <= di_d;
    end
  end

  assign REQ_DI    = di_q;
  assign REQ_DV    = served_q & active;
  assign RAM_AD    = ram_ad_q;
  assign RAM_WE    = ram_we_q;
  assign RAM_DO    = ram_do_q;
  assign DBG_STATE = state_q;

endmodule

// File: doc/shared_ram_arbiter.md
# shared_ram_arbiter

Sequential round-robin arbiter that shares one single-port synchronous work RAM between the three Z80 `CPUCORE` instances (main, sub, sound). It sits between each CPU's `RD`/`WR`/`AD`/`DO` bus and the RAM macro. It sequences one access at a time and returns per-CPU read data with a `DV` (data-valid) flag, which feeds the `CPUCORE` `DV`/`DI` inputs.

## Interface
- `NREQ`, 3: number of requesters (2..4).
- `AW`, 11: shared-RAM address width (2 KB); requester address bits `[AW-1:0]` used.
- `CLK` in 1: system clock; all state changes on rising edge.
- `RESET_N` in 1: reset, synchronous and active-low.
- `REQ_RD` in `NREQ`: per-requester read strobe, level, held until `REQ_DV` seen.
- `REQ_WR` in `NREQ`: per-requester write strobe, level.
- `REQ_AD` in `NREQ*AW`: packed addresses; requester i at `[i*AW +: AW]`.
- `REQ_DO` in `NREQ*8`: packed write data.
- `REQ_DI` out `NREQ*8`: packed latched read data per requester.
- `REQ_DV` out `NREQ`: access complete for requester i (read data valid / write done).
- `RAM_AD` out `AW`: RAM address, registered.
- `RAM_WE` out 1: RAM write enable, registered, one cycle.
- `RAM_DO` out 8: RAM write data, registered.
- `RAM_DI` in 8: RAM read data, valid one cycle after `RAM_AD` is presented.

## Operation
- Pending(i) = (`REQ_RD[i]` | `REQ_WR[i]`) & ~served(i).
- served(i) sets when requester i's access completes. It clears on the first cycle where `REQ_RD[i]`=`REQ_WR[i]`=0.
- `REQ_DV[i]` = served(i) & (`REQ_RD[i]` | `REQ_WR[i]`).
- FSM states: IDLE, ACCESS, DATA.
  - IDLE: if any requester is pending, pick the winner by round-robin starting at `last`+1 mod `NREQ`. Register `RAM_AD`, `RAM_DO` and `RAM_WE` (=`REQ_WR[winner]`), then go to ACCESS. If nothing is pending, stay in IDLE.
  - ACCESS: the RAM sees the address and the write strobe. `RAM_WE` is forced to 0 at the end of this cycle. Go to DATA.
  - DATA:
    - For a read, latch `RAM_DI` into `REQ_DI[winner]`.
    - For either access type, set served(winner) and set `last`=winner. Go to IDLE.
- If `REQ_RD` and `REQ_WR` are both high on one requester, it is treated as a write.
- Requester request dropped after grant: the access still completes and data is still latched. served then clears on the next cycle, so `REQ_DV` never rises.
- Requester request dropped before grant: nothing is performed.
- `REQ_DI[i]` holds its value until requester i's next read completes. Writes do not change it.
- `RAM_AD` and `RAM_DO` hold their last value in IDLE.

## Timing
- Reset values:
  - state=IDLE, `last`=`NREQ`-1 (requester 0 is first priority), served=0.
  - `RAM_WE`=0, `RAM_AD`=0, `RAM_DO`=0, `REQ_DI`=0, `REQ_DV`=0.
- Reset mid-access aborts the access: `RAM_WE` is 0 on the cycle after the reset edge, and no served flag or data update occurs.
- Latency for an uncontended request first seen in IDLE at edge E:
  - `RAM_WE`/`RAM_AD` valid after E.
  - `REQ_DI` and served update at E+2.
  - `REQ_DV` high from E+2 output time.
- One access takes 3 cycles. Worst-case wait for `NREQ`=3 is 9 cycles from pending to `REQ_DV`.
- Back-to-back requests from the same requester need at least one idle cycle with both strobes low in between.
- Fairness: a requester that is continuously pending is granted within `NREQ`-1 other grants.

## Structure
- Package `shared_ram_arb_pkg`:
  - state enum (IDLE/ACCESS/DATA);
  - default `NREQ`/`AW` constants;
  - helper function for the packed-slice index.
- Sub-module `rr_pick`: purely combinational. Takes the pending vector and `last`, returns the winner index and an any-pending flag. It is reused by the interrupt/NMI scheduling logic.

## Test plan
- Single read: preload RAM[0x123]=0xA5, hold `REQ_RD[1]` at 0x123 → `REQ_DI[1]`=0xA5 and `REQ_DV[1]`=1 exactly 2 edges after grant; other `REQ_DV`=0.
- Write then read: req0 writes 0x3C to 0x7FF; `RAM_WE` is high for exactly one cycle with `RAM_AD`=0x7FF and `RAM_DO`=0x3C. A subsequent read by req2 returns 0x3C.
- Contention: all three requesters assert in the same cycle just after reset → grant order 0,1,2. With requests held and re-raised, the next round order is 0,1,2 again; no requester exceeds a 9-cycle wait.
- Withdrawal: req1 drops `REQ_RD` one cycle after grant → `REQ_DV[1]` never rises, served clears, and the next grant goes to the next pending requester.
- Reset mid-access: assert `RESET_N`=0 during ACCESS of a write → `RAM_WE`=0 on the next cycle, all `REQ_DV`=0, and after release requester 0 has priority.
- Simultaneous `RD`+`WR` on req2 → a write occurs (`RAM_WE`=1) and `REQ_DI[2]` is unchanged.
